// File: rtl/multimode_counter.sv
// Stepped, prescaled counter with wrap / saturate / one-shot modes and a registered terminal pulse.
// Define COUNTER_DOWN_EN to honour i_down (count from i_top toward 0); otherwise i_down is ignored.
module multimode_counter #(
   parameter int WIDTH          = 16,
   parameter int INCREMENT      = 1,
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                      i_clk,
   input  logic                      i_reset_n,
   input  logic                      i_enabled,
   input  logic                      i_clear,
   input  logic                      i_load,
   input  logic [WIDTH-1:0]          i_load_value,
   input  logic [WIDTH-1:0]          i_top,
   input  logic [PRESCALE_WIDTH-1:0] i_prescale,
   input  logic [1:0]                i_mode,
   input  logic                      i_start,
   input  logic                      i_down,
   output logic [WIDTH-1:0]          o_value,
   output logic                      o_hitTop,
   output logic                      o_busy,
   output logic                      o_done
);
   typedef enum logic [1:0] { ST_IDLE, ST_RUN, ST_DONE } state_t;

   localparam logic [1:0]                MODE_SAT     = 2'b01;
   localparam logic [1:0]                MODE_ONESHOT = 2'b10;
   localparam logic [WIDTH-1:0]          STEP         = WIDTH'(INCREMENT);
   localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE      = PRESCALE_WIDTH'(1);

   state_t                    state, state_next;
   logic [WIDTH-1:0]          value_q, value_next;
   logic [PRESCALE_WIDTH-1:0] pre_q, pre_next;
   logic                      arrive_q, arrive_next;
   logic                      held_q, held_next;
   logic                      hit_q;
   logic                      count_down, is_oneshot, is_sat, pre_hit, active, terminal;
   logic [WIDTH:0]            up_sum;
   logic [WIDTH-1:0]          step_value, goal_value, restart_value;

`ifdef COUNTER_DOWN_EN
   assign count_down = i_down;
`else
   logic unused_down;
   assign unused_down = i_down;
   assign count_down  = 1'b0;
`endif

   assign is_oneshot = (i_mode == MODE_ONESHOT);
   assign is_sat     = (i_mode == MODE_SAT);
   assign pre_hit    = (pre_q == i_prescale);
   assign active     = !is_oneshot || (state == ST_RUN);
   assign up_sum     = {1'b0, value_q} + {1'b0, STEP};

   // Direction-dependent step, terminal test and the values a wrap/start reloads
   always_comb begin
      if (count_down) begin
         terminal      = (value_q == '0);
         step_value    = (value_q > STEP) ? (value_q - STEP) : '0;
         goal_value    = '0;
         restart_value = i_top;
      end else begin
         terminal      = (value_q >= i_top);
         step_value    = (up_sum > {1'b0, i_top}) ? i_top : up_sum[WIDTH-1:0];
         goal_value    = i_top;
         restart_value = '0;
      end
   end

   // Datapath next state; held_q stops a saturated count from pulsing more than once
   always_comb begin
      value_next  = value_q;
      pre_next    = pre_q;
      arrive_next = 1'b0;
      held_next   = is_sat ? held_q : 1'b0;
      if (i_clear) begin
         value_next = '0;
         pre_next   = '0;
         held_next  = 1'b0;
      end else if (i_load) begin
         value_next = (i_load_value > i_top) ? i_top : i_load_value;
         pre_next   = '0;
         held_next  = 1'b0;
      end else if (i_enabled && is_oneshot && i_start) begin
         value_next = restart_value;
         pre_next   = '0;
      end else if (i_enabled) begin
         pre_next = pre_hit ? '0 : (pre_q + PRE_ONE);
         if (pre_hit && active) begin
            if (!terminal) begin
               value_next  = step_value;
               arrive_next = (step_value == goal_value);
               if (is_sat) held_next = arrive_next;
            end else if (is_sat) begin
               value_next  = goal_value;
               arrive_next = !held_q;
               held_next   = 1'b1;
            end else if (!is_oneshot) begin
               value_next  = restart_value;
               arrive_next = (i_top == '0);
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         value_q  <= '0;
         pre_q    <= '0;
         arrive_q <= 1'b0;
         held_q   <= 1'b0;
         hit_q    <= 1'b0;
      end else begin
         value_q  <= value_next;
         pre_q    <= pre_next;
         arrive_q <= arrive_next;
         held_q   <= held_next;
         hit_q    <= i_clear ? 1'b0 : arrive_q;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) state <= ST_IDLE;
      else            state <= state_next;
   end

   // One-shot sequencing; any other mode parks the FSM in IDLE
   always_comb begin
      state_next = state;
      if (!is_oneshot || i_clear) begin
         state_next = ST_IDLE;
      end else if (i_load) begin
         state_next = state;
      end else if (i_enabled && i_start) begin
         state_next = ST_RUN;
      end else if (i_enabled && pre_hit && (state == ST_RUN) &&
                   (terminal || (step_value == goal_value))) begin
         state_next = ST_DONE;
      end
   end

   always_comb begin
      o_busy = (state == ST_RUN);
      o_done = (state == ST_DONE);
   end

   assign o_value  = value_q;
   assign o_hitTop = hit_q;

endmodule

// File: doc/multimode_counter.md
Name: multimode_counter

Overview:
Parametrised successor to the game-logic tick counter, used for dealer delays, LED blink timing and round timeouts. It counts by a step, with a runtime prescaler, to a runtime top. It supports wrap, saturate and one-shot modes, synchronous clear and load, and a registered one-cycle terminal pulse. One instance replaces several hand-built counters across the design.

Parameters:
WIDTH, 16, count/top/load width
INCREMENT, 1, step per tick (1..2^WIDTH-1)
PRESCALE_WIDTH, 8, width of prescaler divide value

Ports:
i_clk  input  1  system clock
i_reset_n  input  1  asynchronous active-low reset
i_enabled  input  1  high = counting allowed; low freezes value, prescaler and FSM
i_clear  input  1  synchronous clear, 1-cycle pulse
i_load  input  1  synchronous load strobe
i_load_value  input  WIDTH  value for i_load
i_top  input  WIDTH  terminal (upper) count
i_prescale  input  PRESCALE_WIDTH  tick every i_prescale+1 enabled cycles
i_mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap)
i_start  input  1  one-shot trigger pulse
i_down  input  1  count direction (optional feature)
o_value  output  WIDTH  current count
o_hitTop  output  1  registered one-cycle terminal pulse
o_busy  output  1  one-shot RUN state
o_done  output  1  one-shot DONE state

Behaviour:
- Reset (i_reset_n low, async): o_value=0, prescaler=0, o_hitTop=0, FSM=IDLE, o_busy=0, o_done=0.
- Priority per edge: clear > load > start > tick.
  - Clear and load act even when i_enabled=0.
- Clear: o_value=0, prescaler=0, FSM=IDLE, o_hitTop=0.
- Load: o_value=min(i_load_value, i_top), prescaler=0, no pulse, FSM unchanged.
- Prescaler: increments each enabled cycle. When it equals i_prescale, it returns to 0 and a tick occurs that cycle. i_prescale=0 means a tick every enabled cycle.
- Up step on tick: if o_value >= i_top, the count is terminal. Otherwise next = min(o_value+INCREMENT, i_top).
  - Sum is computed at WIDTH+1 bits, so there is no overflow wrap.
- Terminal action on tick:
  - wrap: o_value goes to 0.
  - saturate: o_value holds at i_top.
  - one-shot: o_value holds, FSM goes to DONE.
- o_hitTop: high for exactly one cycle, on the edge after the tick that moves o_value onto i_top.
  - In wrap mode, also on the edge where a wrap occurs onto terminal 0 when i_top=0.
  - Never repeats while saturated or held.
- One-shot FSM:
  - IDLE --i_start--> RUN: o_value=0, prescaler=0.
  - RUN counts on ticks. Reaching i_top goes to DONE.
  - DONE --i_start--> RUN: restart from 0.
  - Ticks are ignored in IDLE and DONE.
  - i_start is ignored in wrap and saturate modes.
  - Leaving one-shot mode forces IDLE on the next edge.
- Wrap/saturate: count on every tick while enabled. o_busy=0, o_done=0.
- i_top lowered below o_value mid-count: the next tick treats the count as terminal. No underflow.
- i_top=0: wrap holds at 0 and pulses o_hitTop every tick. Saturate pulses once.
- Reset asserted mid-count clears all state immediately; counting resumes on the first enabled edge after release.

Optional Feature:
COUNTER_DOWN_EN.
- Defined:
  - i_down=1 counts from i_top toward 0 by INCREMENT, clamped at 0. Terminal value is 0.
  - Wrap reloads i_top. Saturate holds 0. One-shot start loads i_top.
  - o_hitTop pulses on arrival at 0.
  - Direction changes take effect on the next tick.
- Undefined: i_down is present but ignored; counting is up only.

Test Plan:
- WIDTH=4, INCREMENT=1, i_top=5, i_prescale=0, wrap, enabled -> o_value 0,1,2,3,4,5,0,1; o_hitTop high one cycle after 5 appears.
- INCREMENT=3, i_top=10, saturate -> o_value 0,3,6,9,10,10,...; exactly one o_hitTop pulse.
- i_prescale=2, wrap, i_top=3 -> o_value changes every 3rd clock; toggling i_enabled low for 4 clocks stretches the period by 4.
- One-shot, i_top=4, pulse i_start -> o_busy high, o_value 0..4, then o_done=1 and o_busy=0, value held at 4; second i_start restarts from 0.
- i_load with i_load_value=9, i_top=7 -> o_value=7; i_clear with i_load in the same cycle -> o_value=0; i_reset_n low mid-count -> all outputs 0 with no clock edge.
- COUNTER_DOWN_EN, i_down=1, i_top=6, INCREMENT=4, wrap -> o_value 6,2,0,6,2; o_hitTop on each 0.
